// File: rtl/path_oram_ctrl_if.sv
// Request/response bus between a core-side client and the Path ORAM controller.
// Status outputs (overflow flag, stash occupancy) travel on the same bundle.
interface path_oram_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;
    logic              stash_overflow;
    logic [CNT_W-1:0]  stash_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_hit, stash_overflow, stash_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_hit, stash_overflow, stash_count
    );
endinterface

// File: rtl/path_oram_ctrl.sv
// Path ORAM controller: position map, stash and bucket tree in registers, with a
// fixed-latency read-path / update / evict-path sequence per request.
module path_oram_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEVELS = 4,
    parameter int unsigned Z      = 4,
    parameter int unsigned STASH  = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    path_oram_ctrl_if.slave bus
);
    localparam int unsigned LEAF_W  = LEVELS - 1;
    localparam int unsigned BUCKETS = (1 << LEVELS) - 1;
    localparam int unsigned BKT_W   = LEVELS;
    localparam int unsigned LVL_W   = (LEVELS > 2) ? $clog2(LEVELS) : 1;
    localparam int unsigned CNT_W   = $clog2(STASH + 1);
    localparam int unsigned BLOCKS  = 1 << ADDR_W;

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] a;
        logic [LEAF_W-1:0] leaf;
        logic [DATA_W-1:0] d;
    } entry_t;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_UPDATE, S_EVICT, S_RESP} state_t;

    state_t            r_state, w_state_nx;
    logic [LVL_W-1:0]  r_lvl, w_lvl_nx;
    logic [15:0]       r_lfsr;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_hit;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [LEAF_W-1:0] r_leaf;
    logic [LEAF_W-1:0] r_pos [BLOCKS];
    entry_t            r_tree [BUCKETS][Z];
    entry_t            r_stash [STASH];

    entry_t            w_tree [BUCKETS][Z];
    entry_t            w_stash [STASH];
    logic              w_ovf;
    logic              w_found;
    logic [DATA_W-1:0] w_hit_data;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_accept;
    logic [31:0]       w_sh;
    logic [BKT_W-1:0]  w_bkt;
    logic [LEAF_W-1:0] w_new_leaf;
    logic [15:0]       w_lfsr_nx;

    assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
    assign w_sh       = 32'(LEAF_W) - 32'(r_lvl);
    assign w_bkt      = (BKT_W'(1) << r_lvl) + BKT_W'(r_leaf >> w_sh) - BKT_W'(1);
    assign w_new_leaf = r_lfsr[LEAF_W-1:0];
    // Galois LFSR for x^16+x^14+x^13+x^11+1
    assign w_lfsr_nx  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // FSM next state and level counter
    always_comb begin
        w_state_nx = r_state;
        w_lvl_nx   = r_lvl;
        unique case (r_state)
            S_IDLE: if (bus.req_valid) begin
                w_state_nx = S_READ;
                w_lvl_nx   = '0;
            end
            S_READ: begin
                if (r_lvl == LVL_W'(LEVELS - 1)) w_state_nx = S_UPDATE;
                else                             w_lvl_nx   = r_lvl + LVL_W'(1);
            end
            S_UPDATE: begin
                w_state_nx = S_EVICT;
                w_lvl_nx   = LVL_W'(LEVELS - 1);
            end
            S_EVICT: begin
                if (r_lvl == '0) w_state_nx = S_RESP;
                else             w_lvl_nx   = r_lvl - LVL_W'(1);
            end
            S_RESP: if (r_resp_valid && bus.resp_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Stash/tree datapath for the current step
    always_comb begin
        logic placed;
        logic found;
        w_tree     = r_tree;
        w_stash    = r_stash;
        w_ovf      = 1'b0;
        w_found    = 1'b0;
        w_hit_data = '0;
        w_cnt      = '0;
        placed     = 1'b0;
        found      = 1'b0;
        if (r_state == S_READ) begin
            for (int z = 0; z < Z; z++) begin
                if (r_tree[w_bkt][z].v) begin
                    placed = 1'b0;
                    for (int j = 0; j < STASH; j++) begin
                        if (!placed && !w_stash[j].v) begin
                            w_stash[j] = r_tree[w_bkt][z];
                            placed     = 1'b1;
                        end
                    end
                    if (!placed) w_ovf = 1'b1;
                    w_tree[w_bkt][z] = '0;
                end
            end
        end else if (r_state == S_UPDATE) begin
            for (int j = 0; j < STASH; j++) begin
                if (!found && r_stash[j].v && r_stash[j].a == r_addr) begin
                    found           = 1'b1;
                    w_hit_data      = r_stash[j].d;
                    w_stash[j].leaf = w_new_leaf;
                    if (r_write) w_stash[j].d = r_wdata;
                end
            end
            w_found = found;
            if (!found && r_write) begin
                placed = 1'b0;
                for (int j = 0; j < STASH; j++) begin
                    if (!placed && !r_stash[j].v) begin
                        w_stash[j] = '{v: 1'b1, a: r_addr, leaf: w_new_leaf, d: r_wdata};
                        placed     = 1'b1;
                    end
                end
                if (!placed) w_ovf = 1'b1;
            end
        end else if (r_state == S_EVICT) begin
            // Path buckets were emptied in READ; refill greedily, lowest stash index first
            for (int z = 0; z < Z; z++) begin
                placed = 1'b0;
                for (int j = 0; j < STASH; j++) begin
                    if (!placed && w_stash[j].v &&
                        ((w_stash[j].leaf >> w_sh) == (r_leaf >> w_sh))) begin
                        w_tree[w_bkt][z] = w_stash[j];
                        w_stash[j]       = '0;
                        placed           = 1'b1;
                    end
                end
            end
        end
        for (int j = 0; j < STASH; j++) w_cnt = w_cnt + CNT_W'(w_stash[j].v);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lvl        <= '0;
            r_lfsr       <= SEED;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_hit        <= 1'b0;
            r_ovf        <= 1'b0;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_leaf       <= '0;
            for (int a = 0; a < BLOCKS; a++) r_pos[a] <= LEAF_W'(a);
            for (int b = 0; b < BUCKETS; b++)
                for (int z = 0; z < Z; z++) r_tree[b][z] <= '0;
            for (int j = 0; j < STASH; j++) r_stash[j] <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_lvl       <= w_lvl_nx;
            r_lfsr      <= w_lfsr_nx;
            r_req_ready <= (w_state_nx == S_IDLE);
            r_tree      <= w_tree;
            r_stash     <= w_stash;
            r_cnt       <= w_cnt;
            if (w_ovf) r_ovf <= 1'b1;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_leaf  <= r_pos[bus.req_addr];
            end
            if (r_state == S_UPDATE) begin
                r_hit         <= w_found;
                r_rdata       <= w_hit_data;
                r_pos[r_addr] <= w_new_leaf;
            end
            // Response goes valid one cycle into RESP, keeping latency at 2*LEVELS+2
            if (r_state == S_RESP && !r_resp_valid)   r_resp_valid <= 1'b1;
            else if (r_resp_valid && bus.resp_ready) r_resp_valid <= 1'b0;
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_rdata;
    assign bus.resp_hit       = r_hit;
    assign bus.stash_overflow = r_ovf;
    assign bus.stash_count    = r_cnt;
endmodule

// File: tb/tb_path_oram_ctrl.sv
// Bench for path_oram_ctrl: a default instance checked against a flat memory model,
// plus a tiny-stash instance exercising the overflow path.
module tb_path_oram_ctrl;
    localparam int unsigned LAT = 2 * 4 + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    path_oram_ctrl_if #(.ADDR_W(4), .DATA_W(32), .CNT_W(5)) b_if();
    path_oram_ctrl_if #(.ADDR_W(6), .DATA_W(32), .CNT_W(2)) s_if();

    path_oram_ctrl #(.ADDR_W(4), .DATA_W(32), .LEVELS(4), .Z(4), .STASH(16), .SEED(16'hACE1))
        u_big (.clk(clk), .rst(rst), .bus(b_if.slave));
    path_oram_ctrl #(.ADDR_W(6), .DATA_W(32), .LEVELS(4), .Z(1), .STASH(2), .SEED(16'h1D2B))
        u_small (.clk(clk), .rst(rst), .bus(s_if.slave));

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    bit          wrt [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input bit w, input logic [5:0] a,
                         input logic [31:0] d);
        if (sel) begin
            s_if.req_valid = v; s_if.req_write = w; s_if.req_addr = a; s_if.req_wdata = d;
        end else begin
            b_if.req_valid = v; b_if.req_write = w; b_if.req_addr = a[3:0]; b_if.req_wdata = d;
        end
    endtask

    task automatic set_rr(input bit sel, input bit v);
        if (sel) s_if.resp_ready = v;
        else     b_if.resp_ready = v;
    endtask

    task automatic sample(input bit sel, output logic rv, output logic rr, output logic [31:0] d,
                          output logic h, output logic ov, output int c);
        if (sel) begin
            rv = s_if.resp_valid; rr = s_if.req_ready; d = s_if.resp_rdata;
            h = s_if.resp_hit; ov = s_if.stash_overflow; c = int'(s_if.stash_count);
        end else begin
            rv = b_if.resp_valid; rr = b_if.req_ready; d = b_if.resp_rdata;
            h = b_if.resp_hit; ov = b_if.stash_overflow; c = int'(b_if.stash_count);
        end
    endtask

    // One full request/response transaction; called #1 after a clock edge
    task automatic do_op(input bit sel, input bit wr, input logic [5:0] a, input logic [31:0] wd,
                         input int hold, output logic [31:0] rd, output logic hit, output int lat);
        logic rv, rr, h, ov;
        logic [31:0] d;
        int c, bnd;
        bnd = 0;
        sample(sel, rv, rr, d, h, ov, c);
        while (!rr && bnd < 100) begin
            @(posedge clk); #1; bnd++;
            sample(sel, rv, rr, d, h, ov, c);
        end
        chk("req_ready_wait", 64'(rr), 64'(1));
        drive(sel, 1'b1, wr, a, wd);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 6'd0, 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
            sample(sel, rv, rr, d, h, ov, c);
        end while (!rv && lat < 40);
        rd  = d;
        hit = h;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            sample(sel, rv, rr, d, h, ov, c);
            chk("hold_valid", 64'(rv), 64'(1));
            chk("hold_rdata", 64'(d), 64'(rd));
            chk("hold_hit", 64'(h), 64'(hit));
            chk("hold_req_ready", 64'(rr), 64'(0));
        end
        set_rr(sel, 1'b1);
        @(posedge clk); #1;
        set_rr(sel, 1'b0);
        sample(sel, rv, rr, d, h, ov, c);
        chk("resp_valid_drop", 64'(rv), 64'(0));
    endtask

    initial begin
        logic rv, rr, h, ov, hit, exp_hit, seen_ovf;
        logic [31:0] d, rd, wd, exp_d;
        logic [5:0] a;
        bit wr;
        int c, c0, lat, hold, nblk;

        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
        set_rr(1'b0, 1'b0);
        set_rr(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin mem[i] = '0; wrt[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        sample(1'b0, rv, rr, d, h, ov, c);
        chk("rst_req_ready", 64'(rr), 64'(1));
        chk("rst_resp_valid", 64'(rv), 64'(0));
        chk("rst_rdata", 64'(d), 64'(0));
        chk("rst_hit", 64'(h), 64'(0));
        chk("rst_ovf", 64'(ov), 64'(0));
        chk("rst_count", 64'(c), 64'(0));

        do_op(1'b0, 1'b1, 6'd3, 32'hDEADBEEF, 0, rd, hit, lat);
        chk("w3_rdata", 64'(rd), 64'(0));
        chk("w3_hit", 64'(hit), 64'(0));
        chk("w3_latency", 64'(lat), 64'(LAT));
        mem[3] = 32'hDEADBEEF; wrt[3] = 1'b1;

        sample(1'b0, rv, rr, d, h, ov, c0);
        do_op(1'b0, 1'b0, 6'd9, 32'd0, 0, rd, hit, lat);
        sample(1'b0, rv, rr, d, h, ov, c);
        chk("r9_rdata", 64'(rd), 64'(0));
        chk("r9_hit", 64'(hit), 64'(0));
        chk("r9_latency", 64'(lat), 64'(LAT));
        chk("r9_count", 64'(c), 64'(c0));

        do_op(1'b0, 1'b0, 6'd3, 32'd0, 5, rd, hit, lat);
        chk("r3_rdata", 64'(rd), 64'(32'hDEADBEEF));
        chk("r3_hit", 64'(hit), 64'(1));
        chk("r3_latency", 64'(lat), 64'(LAT));

        // Random traffic against a flat memory model
        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = 6'($urandom_range(0, 15));
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            exp_hit = wrt[a];
            exp_d   = wrt[a] ? mem[a] : 32'd0;
            do_op(1'b0, wr, a, wd, hold, rd, hit, lat);
            chk("rand_rdata", 64'(rd), 64'(exp_d));
            chk("rand_hit", 64'(hit), 64'(exp_hit));
            chk("rand_latency", 64'(lat), 64'(LAT));
            if (wr) begin mem[a] = wd; wrt[a] = 1'b1; end
            nblk = 0;
            for (int k = 0; k < 16; k++) nblk += int'(wrt[k]);
            sample(1'b0, rv, rr, d, h, ov, c);
            chk("rand_ovf", 64'(ov), 64'(0));
            chk("rand_count_bound", 64'(c <= nblk), 64'(1));
        end

        // Reset in the middle of READ
        sample(1'b0, rv, rr, d, h, ov, c);
        chk("mid_req_ready_pre", 64'(rr), 64'(1));
        drive(1'b0, 1'b1, 1'b1, 6'd5, 32'h12345678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        sample(1'b0, rv, rr, d, h, ov, c);
        chk("mid_rst_req_ready", 64'(rr), 64'(1));
        chk("mid_rst_resp_valid", 64'(rv), 64'(0));
        chk("mid_rst_count", 64'(c), 64'(0));
        chk("mid_rst_ovf", 64'(ov), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; wrt[i] = 1'b0; end
        do_op(1'b0, 1'b0, 6'd3, 32'd0, 0, rd, hit, lat);
        chk("post_rst_r3_rdata", 64'(rd), 64'(0));
        chk("post_rst_r3_hit", 64'(hit), 64'(0));

        // Tiny stash: 64 blocks cannot fit in 15 slots + 2 stash entries
        seen_ovf = 1'b0;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            do_op(1'b1, 1'b1, 6'(i), wd, 0, rd, hit, lat);
            chk("small_w_latency", 64'(lat), 64'(LAT));
            mem[i] = wd; wrt[i] = 1'b1;
            sample(1'b1, rv, rr, d, h, ov, c);
            if (seen_ovf) chk("small_ovf_sticky_w", 64'(ov), 64'(1));
            if (ov) seen_ovf = 1'b1;
            chk("small_count_bound", 64'(c <= 2), 64'(1));
        end
        sample(1'b1, rv, rr, d, h, ov, c);
        chk("small_ovf_set", 64'(ov), 64'(1));
        for (int i = 0; i < 64; i++) begin
            do_op(1'b1, 1'b0, 6'(i), 32'd0, 0, rd, hit, lat);
            sample(1'b1, rv, rr, d, h, ov, c);
            if (seen_ovf) chk("small_ovf_sticky_r", 64'(ov), 64'(1));
            if (ov) seen_ovf = 1'b1;
            else begin
                chk("small_rdata", 64'(rd), 64'(mem[i]));
                chk("small_hit", 64'(hit), 64'(1));
            end
        end

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sample(1'b1, rv, rr, d, h, ov, c);
        chk("small_ovf_cleared", 64'(ov), 64'(0));
        chk("small_count_cleared", 64'(c), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
